posit_dot_sequencer: RTL and testbench
======================================

// Module: posit_dot_sequencer
// PURPOSE
//  Upstream operand sequencer for the posit exact-multiply-accumulate (EMA) unit.
//  Accepts a job (start + vector length), clears the EMA accumulator, then streams
//  16-bit posit operand pairs into it with valid/ready flow control.
//  After the last pair and the EMA pipeline latency, it captures the rounded posit
//  dot product and signals done. Used by the vision convolution path.
// PARAMETERS
//  N_BITS    16  posit word width (operands and result)
//  LEN_W     8   width of job length field; max vector length = 2^LEN_W-1
//  EMA_LAT   4   cycles from last io_inValid at EMA to earliest valid final result
// PORTS
//  clock            in   1       single clock, rising edge
//  reset            in   1       synchronous, active-high
//  io_start         in   1       job start strobe; sampled only in IDLE
//  io_len           in   LEN_W   number of operand pairs; sampled with io_start
//  io_busy          out  1       high in every state except IDLE
//  io_done          out  1       one-cycle pulse when io_result is updated
//  io_result        out  N_BITS  captured dot product; held until next capture
//  op_valid         in   1       operand pair valid
//  op_ready         out  1       sequencer accepts pair (STREAM only)
//  op_a, op_b       in   N_BITS  operand posits
//  ema_clear        out  1       accumulator clear to EMA (ORed with EMA reset at top)
//  ema_inValid      out  1       drives EMA io_inValid
//  ema_A, ema_B     out  N_BITS  drive EMA io_A / io_B
//  ema_positOut     in   N_BITS  EMA io_positOut
//  ema_outValid     in   1       EMA io_outValid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (io_result=0x0000, counters 0).
//  FSM: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE.
//   IDLE: io_start=1 latches io_len into remaining count, go CLEAR.
//   CLEAR: ema_clear=1 for exactly one cycle; go STREAM, or DRAIN if len=0.
//   STREAM: op_ready=1. Handshake = op_valid&op_ready. Each handshake registers
//    op_a/op_b onto ema_A/ema_B and asserts ema_inValid the next cycle for exactly
//    one cycle; decrement remaining. On the handshake taking remaining to 0, drop
//    op_ready in the next cycle and go DRAIN. No handshake -> ema_inValid=0;
//    ema_A/B hold their last values.
//   DRAIN: load drain counter with EMA_LAT on entry; count down to 0. At 0, capture
//    ema_positOut into io_result in the first cycle with ema_outValid=1 (wait
//    indefinitely if low), then go DONE. Special case len=0: skip the wait and
//    capture 0x0000 (posit zero); EMA outputs are ignored.
//   DONE: io_done=1 for one cycle; go IDLE. io_busy falls the same cycle as IDLE.
//  io_start while busy: ignored, not queued.
//  op_valid outside STREAM: ignored (op_ready=0, no EMA write).
//  Result is passed through bit-exact; NaR (0x8000) is not altered.
//  Synchronous reset mid-job: aborts immediately, state and outputs to reset
//   values, no io_done. A partial EMA accumulation is discarded by the next CLEAR.
//  Max throughput: one pair per cycle. Job latency = 1 + len + EMA_LAT + 2 cycles
//   minimum (start to done pulse).
// STRUCTURE
//  Shared package posit_pkg: N_BITS, posit zero 16'h0000, NaR 16'h8000,
//   state encoding enum {IDLE,CLEAR,STREAM,DRAIN,DONE}.
//  Single module; no sub-modules. The counters and the 5-state FSM sit in one
//   always block, with registered EMA-side outputs.
// TESTING  (EMA driven by the behavioural reference model, EMA_LAT=4)
//  len=4, pairs 0x4000*0x4000 (1.0*1.0) back-to-back -> 4 ema_inValid pulses on
//   consecutive cycles, one ema_clear before them, io_result=0x6000 (4.0), io_done
//   once.
//  len=3 with op_valid toggling 1,0,1,0,1 -> exactly 3 EMA writes, ema_A/B stable
//   during gaps, same result as with no gaps.
//  len=0 -> ema_clear pulse, no ema_inValid, io_result=0x0000, io_done pulse.
//  io_start pulsed during STREAM -> ignored; len unchanged; single io_done.
//  reset asserted after 2 of 5 pairs -> all outputs 0, IDLE next cycle, no io_done;
//   new job len=2 of 0x5000*0x4000 -> io_result=0x6000 (2.0+2.0).
//  ema_outValid held low for 6 cycles after drain count expires -> sequencer waits,
//   then captures on first high; io_busy stays 1 throughout.

Source files
------------

// File: rtl/posit_dot_sequencer_pkg.sv
// Shared definitions for the posit dot-product operand sequencer:
// default widths, EMA pipeline latency, special posit codes and FSM encoding.
package posit_dot_sequencer_pkg;

    localparam int DEF_N_BITS  = 16;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_EMA_LAT = 4;

    localparam logic [DEF_N_BITS-1:0] POSIT_ZERO = 16'h0000;
    localparam logic [DEF_N_BITS-1:0] POSIT_NAR  = 16'h8000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/posit_dot_sequencer_if.sv
// Operand-pair stream into the sequencer. A pair transfers on a rising clock
// edge where op_valid && op_ready; the producer holds op_a/op_b stable while op_valid waits.
interface posit_dot_sequencer_if #(
    parameter int N_BITS = 16
) ();
    logic              op_valid;
    logic              op_ready;
    logic [N_BITS-1:0] op_a;
    logic [N_BITS-1:0] op_b;

    modport master (
        output op_valid,
        output op_a,
        output op_b,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_a,
        input  op_b,
        output op_ready
    );
endinterface

// File: rtl/posit_dot_sequencer.sv
// Sequences one dot-product job through the posit EMA unit: clear the accumulator,
// stream operand pairs, wait out the EMA latency, then capture the rounded result.
module posit_dot_sequencer
    import posit_dot_sequencer_pkg::*;
#(
    parameter int N_BITS  = DEF_N_BITS,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int EMA_LAT = DEF_EMA_LAT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic [LEN_W-1:0]     io_len,
    output logic                 io_busy,
    output logic                 io_done,
    output logic [N_BITS-1:0]    io_result,
    posit_dot_sequencer_if.slave op,
    output logic                 ema_clear,
    output logic                 ema_inValid,
    output logic [N_BITS-1:0]    ema_A,
    output logic [N_BITS-1:0]    ema_B,
    input  logic [N_BITS-1:0]    ema_positOut,
    input  logic                 ema_outValid,
    output seq_state_t           o_dbg_state
);

    localparam int DRAIN_W = $clog2(EMA_LAT + 1);

    seq_state_t           r_state;
    logic [LEN_W-1:0]     r_remaining;
    logic [DRAIN_W-1:0]   r_drain;
    logic                 r_zero_len;
    logic                 r_busy;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_clear;
    logic                 r_in_valid;
    logic [N_BITS-1:0]    r_ema_a;
    logic [N_BITS-1:0]    r_ema_b;
    logic [N_BITS-1:0]    r_result;

    logic                 w_hs;
    logic                 w_last_pair;

    assign w_hs        = op.op_valid && r_ready;
    assign w_last_pair = (r_remaining == LEN_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_drain     <= '0;
            r_zero_len  <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_clear     <= 1'b0;
            r_in_valid  <= 1'b0;
            r_ema_a     <= '0;
            r_ema_b     <= '0;
            r_result    <= '0;
        end else begin
            // Pulse outputs default low; each state raises them for the next cycle only.
            r_clear    <= 1'b0;
            r_in_valid <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (io_start) begin
                        r_remaining <= io_len;
                        r_zero_len  <= (io_len == '0);
                        r_busy      <= 1'b1;
                        r_clear     <= 1'b1;
                        r_state     <= CLEAR;
                    end
                end

                CLEAR: begin
                    if (r_zero_len) begin
                        r_drain <= DRAIN_W'(EMA_LAT);
                        r_state <= DRAIN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= STREAM;
                    end
                end

                STREAM: begin
                    if (w_hs) begin
                        r_ema_a     <= op.op_a;
                        r_ema_b     <= op.op_b;
                        r_in_valid  <= 1'b1;
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last_pair) begin
                            r_ready <= 1'b0;
                            r_drain <= DRAIN_W'(EMA_LAT);
                            r_state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // Zero-length jobs never wrote the EMA, so its outputs are not trusted.
                    if (r_drain != '0) begin
                        r_drain <= r_drain - DRAIN_W'(1);
                    end else if (r_zero_len) begin
                        r_result <= POSIT_ZERO;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else if (ema_outValid) begin
                        r_result <= ema_positOut;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end

                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_busy     = r_busy;
    assign io_done     = r_done;
    assign io_result   = r_result;
    assign op.op_ready = r_ready;
    assign ema_clear   = r_clear;
    assign ema_inValid = r_in_valid;
    assign ema_A       = r_ema_a;
    assign ema_B       = r_ema_b;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_posit_dot_sequencer.sv
// Directed bench for posit_dot_sequencer with a small EMA stand-in that sums
// products of the few posit codes used here (1.0, 2.0) and re-encodes the sum.
module tb_posit_dot_sequencer;
    import posit_dot_sequencer_pkg::*;

    localparam int EMA_LAT = 4;

    logic        clock;
    logic        reset;
    logic        io_start;
    logic [7:0]  io_len;
    logic        io_busy;
    logic        io_done;
    logic [15:0] io_result;
    logic        ema_clear;
    logic        ema_inValid;
    logic [15:0] ema_A;
    logic [15:0] ema_B;
    logic [15:0] tb_positOut;
    logic        tb_outValid;
    seq_state_t  dbg_state;

    posit_dot_sequencer_if #(.N_BITS(16)) op_if ();

    posit_dot_sequencer #(.N_BITS(16), .LEN_W(8), .EMA_LAT(EMA_LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_start     (io_start),
        .io_len       (io_len),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_result    (io_result),
        .op           (op_if),
        .ema_clear    (ema_clear),
        .ema_inValid  (ema_inValid),
        .ema_A        (ema_A),
        .ema_B        (ema_B),
        .ema_positOut (tb_positOut),
        .ema_outValid (tb_outValid),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- EMA stand-in ----------------
    function automatic int dec(input logic [15:0] p);
        case (p)
            16'h4000: return 1;
            16'h5000: return 2;
            16'h6000: return 4;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [15:0] enc(input int v);
        case (v)
            0:       return 16'h0000;
            1:       return 16'h4000;
            2:       return 16'h5000;
            3:       return 16'h5800;
            4:       return 16'h6000;
            6:       return 16'h6400;
            8:       return 16'h6800;
            default: return 16'h7fff;
        endcase
    endfunction

    int m_acc = 0;
    int m_age = 0;
    bit m_has = 1'b0;
    int stall_extra = 0;
    bit force_nar = 1'b0;

    always @(posedge clock) begin
        if (reset || ema_clear) begin
            m_acc <= 0;
            m_has <= 1'b0;
            m_age <= 0;
        end else if (ema_inValid) begin
            m_acc <= m_acc + dec(ema_A) * dec(ema_B);
            m_has <= 1'b1;
            m_age <= 0;
        end else if (m_age < 1000) begin
            m_age <= m_age + 1;
        end
    end

    assign tb_outValid = m_has && (m_age >= EMA_LAT - 1 + stall_extra);
    assign tb_positOut = force_nar ? 16'h8000 : enc(m_acc);

    // ---------------- monitor ----------------
    int clr_cnt = 0, inv_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int first_inv = -1, last_inv = -1;
    int done_cyc = 0;
    logic [15:0] done_res = '0;
    logic done_busy = 1'b0;

    always @(negedge clock) begin
        if (!reset) begin
            if (ema_clear) begin
                clr_cnt++;
                first_inv = -1;
            end
            if (ema_inValid) begin
                inv_cnt++;
                if (first_inv < 0) first_inv = cyc;
                last_inv = cyc;
            end
            if (io_busy) busy_cnt++;
            if (io_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_res  = io_result;
                done_busy = io_busy;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_bad = 0;
    int start_cyc = 0;
    int b_clr = 0, b_inv = 0, b_done = 0, b_busy = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_job(input int len);
        @(negedge clock); #1;
        b_clr     = clr_cnt;
        b_inv     = inv_cnt;
        b_done    = done_cnt;
        b_busy    = busy_cnt;
        start_cyc = cyc;
        io_start  = 1'b1;
        io_len    = 8'(len);
        @(negedge clock); #1;
        io_start  = 1'b0;
    endtask

    task automatic send_pairs(input string tag, input int n, input logic [15:0] a,
                              input logic [15:0] b, input bit gaps);
        int sent = 0;
        int guard = 0;
        bit gap_next = 1'b0;
        bit prev_gap = 1'b0;
        while (sent < n && guard < 100) begin
            @(negedge clock); #1;
            guard++;
            if (prev_gap) begin
                check_eq({tag, "_gap_hold_a"}, 32'(ema_A), 32'(a));
                check_eq({tag, "_gap_hold_b"}, 32'(ema_B), 32'(b));
                check_eq({tag, "_gap_no_write"}, 32'(ema_inValid), 32'd0);
                prev_gap = 1'b0;
            end
            if (gap_next) begin
                op_if.op_valid = 1'b0;
                op_if.op_a     = 16'h1234;
                op_if.op_b     = 16'h1234;
                gap_next       = 1'b0;
                prev_gap       = 1'b1;
            end else begin
                op_if.op_valid = 1'b1;
                op_if.op_a     = a;
                op_if.op_b     = b;
                if (op_if.op_ready) begin
                    sent++;
                    gap_next = gaps;
                end
            end
        end
        check_eq({tag, "_pairs_accepted"}, 32'(sent), 32'(n));
        @(negedge clock); #1;
        op_if.op_valid = 1'b0;
    endtask

    task automatic job_check(input string tag, input logic [15:0] exp_res,
                             input int exp_inv, input int exp_lat);
        int n = 0;
        while (done_cnt == b_done && n < 100) begin
            @(negedge clock); #1;
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt != b_done), 32'd1);
        check_eq({tag, "_result"}, 32'(done_res), 32'(exp_res));
        check_eq({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(exp_lat));
        check_eq({tag, "_busy_at_done"}, 32'(done_busy), 32'd1);
        repeat (3) begin
            @(negedge clock); #1;
        end
        check_eq({tag, "_busy_after"}, 32'(io_busy), 32'd0);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt - b_done), 32'd1);
        check_eq({tag, "_clear_pulses"}, 32'(clr_cnt - b_clr), 32'd1);
        check_eq({tag, "_ema_writes"}, 32'(inv_cnt - b_inv), 32'(exp_inv));
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt - b_busy), 32'(exp_lat));
        check_eq({tag, "_result_held"}, 32'(io_result), 32'(exp_res));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset          = 1'b1;
        io_start       = 1'b0;
        io_len         = '0;
        op_if.op_valid = 1'b0;
        op_if.op_a     = '0;
        op_if.op_b     = '0;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        check_eq("rst_busy", 32'(io_busy), 32'd0);
        check_eq("rst_done", 32'(io_done), 32'd0);
        check_eq("rst_result", 32'(io_result), 32'h0);
        check_eq("rst_ready", 32'(op_if.op_ready), 32'd0);
        check_eq("rst_clear", 32'(ema_clear), 32'd0);
        check_eq("rst_invalid", 32'(ema_inValid), 32'd0);
        check_eq("rst_ema_a", 32'(ema_A), 32'h0);
        reset = 1'b0;

        // op_valid while idle must not reach the EMA
        @(negedge clock); #1;
        b_inv = inv_cnt;
        op_if.op_valid = 1'b1;
        op_if.op_a     = 16'h5000;
        op_if.op_b     = 16'h5000;
        repeat (3) begin
            @(negedge clock); #1;
            check_eq("idle_ready", 32'(op_if.op_ready), 32'd0);
        end
        op_if.op_valid = 1'b0;
        @(negedge clock); #1;
        check_eq("idle_no_write", 32'(inv_cnt - b_inv), 32'd0);
        check_eq("idle_ema_a", 32'(ema_A), 32'h0);

        // len=4, back-to-back 1.0*1.0 -> 4.0
        start_job(4);
        send_pairs("b2b", 4, 16'h4000, 16'h4000, 1'b0);
        check_eq("b2b_write_span", 32'(last_inv - first_inv), 32'd3);
        job_check("b2b", 16'h6000, 4, 11);

        // len=3 with gaps -> 3.0
        start_job(3);
        send_pairs("gap", 3, 16'h4000, 16'h4000, 1'b1);
        job_check("gap", 16'h5800, 3, 12);

        // len=0 -> posit zero; EMA outputs ignored
        force_nar = 1'b1;
        start_job(0);
        job_check("len0", 16'h0000, 0, 7);
        force_nar = 1'b0;

        // io_start during STREAM is ignored
        start_job(4);
        fork
            send_pairs("busy_start", 4, 16'h4000, 16'h4000, 1'b0);
            begin
                repeat (3) @(negedge clock);
                #1;
                io_start = 1'b1;
                io_len   = 8'd9;
                @(negedge clock); #1;
                io_start = 1'b0;
            end
        join
        job_check("busy_start", 16'h6000, 4, 11);

        // NaR passes through bit-exact
        force_nar = 1'b1;
        start_job(1);
        send_pairs("nar", 1, 16'h4000, 16'h4000, 1'b0);
        job_check("nar", 16'h8000, 1, 8);
        force_nar = 1'b0;

        // EMA result late by 6 cycles -> sequencer waits
        stall_extra = 6;
        start_job(2);
        send_pairs("stall", 2, 16'h4000, 16'h4000, 1'b0);
        job_check("stall", 16'h5000, 2, 15);
        stall_extra = 0;

        // reset after 2 of 5 pairs
        start_job(5);
        send_pairs("abort", 2, 16'h4000, 16'h4000, 1'b0);
        @(negedge clock); #1;
        check_eq("abort_busy_before", 32'(io_busy), 32'd1);
        reset = 1'b1;
        @(negedge clock); #1;
        check_eq("abort_state", 32'(dbg_state), 32'(IDLE));
        check_eq("abort_busy", 32'(io_busy), 32'd0);
        check_eq("abort_result", 32'(io_result), 32'h0);
        check_eq("abort_ready", 32'(op_if.op_ready), 32'd0);
        check_eq("abort_ema_a", 32'(ema_A), 32'h0);
        check_eq("abort_invalid", 32'(ema_inValid), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        check_eq("abort_no_done", 32'(done_cnt - b_done), 32'd0);

        // fresh job after abort: 2.0 + 2.0 -> 4.0
        start_job(2);
        send_pairs("after_abort", 2, 16'h5000, 16'h4000, 1'b0);
        job_check("after_abort", 16'h6000, 2, 9);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
